// File: rtl/enc_repacker_if.sv
// enc_repacker_if: bundles the encoder-side input beat and the
// formatter-side request/response of enc_repacker.
//   master : drives enc_valid/enc_count/enc_last/enc_data and for_request,
//            observes enc_ready, for_valid/for_count/for_last/for_data,
//            buf_level (encoder core + serializer side, or a bench).
//   slave  : the repacker itself.
interface enc_repacker_if #(
  parameter int SYM_NUM   = 8,
  parameter int SYM_WIDTH = 8,
  parameter int BUF_SYM   = 24
);
  localparam int CW = $clog2(SYM_NUM + 1);
  localparam int LW = $clog2(BUF_SYM + 1);

  logic                         enc_valid;
  logic                         enc_ready;
  logic [CW-1:0]                enc_count;
  logic                         enc_last;
  logic [SYM_NUM*SYM_WIDTH-1:0] enc_data;
  logic [CW-1:0]                for_request;
  logic                         for_valid;
  logic [CW-1:0]                for_count;
  logic                         for_last;
  logic [SYM_NUM*SYM_WIDTH-1:0] for_data;
  logic [LW-1:0]                buf_level;

  modport master (
    output enc_valid, enc_count, enc_last, enc_data, for_request,
    input  enc_ready, for_valid, for_count, for_last, for_data, buf_level
  );

  modport slave (
    input  enc_valid, enc_count, enc_last, enc_data, for_request,
    output enc_ready, for_valid, for_count, for_last, for_data, buf_level
  );
endinterface

// File: rtl/enc_repacker.sv
// enc_repacker: symbol FIFO-shifter between the RS encoder core and the
// output serializer. Accepts variable-count symbol beats, hands out exactly
// the number of symbols requested each cycle (unused lanes zero), tracks the
// frame end and flushes a short final beat.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (clears buffer and frame state)
//   bus    : enc_repacker_if.slave
//            enc_valid/enc_ready/enc_count/enc_last/enc_data  input beats
//            for_request -> for_valid/for_count/for_last/for_data  output
//            buf_level  registered occupancy in symbols
// Lane 0 is the oldest symbol on every bus and in the buffer (LSBs).
module enc_repacker #(
  parameter int SYM_NUM   = 8,
  parameter int SYM_WIDTH = 8,
  parameter int BUF_SYM   = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  enc_repacker_if.slave bus
);
  localparam int CW = $clog2(SYM_NUM + 1);
  localparam int LW = $clog2(BUF_SYM + 1);
  localparam int DW = SYM_NUM * SYM_WIDTH;
  localparam int BW = BUF_SYM * SYM_WIDTH;

  // Registered state
  logic [BW-1:0] buf_r;
  logic [LW-1:0] level_r;
  logic          last_pend_r;
  logic [LW-1:0] last_pos_r;

  // Combinational signals
  logic [CW-1:0] req_s;
  logic [CW-1:0] cnt_s;
  logic          ready_s;
  logic          out_valid_s;
  logic [CW-1:0] out_count_s;
  logic          out_last_s;
  logic [DW-1:0] out_data_s;
  logic          push_s;
  logic [CW-1:0] push_n_s;
  logic [CW-1:0] pop_n_s;
  logic [LW-1:0] keep_s;
  logic [DW-1:0] push_data_s;
  logic [BW-1:0] keep_mask_s;
  logic [BW-1:0] buf_next_s;
  logic [LW-1:0] level_next_s;
  logic          last_pend_next_s;
  logic [LW-1:0] last_pos_next_s;

  // Clamp request and input count to the lane count.
  always_comb begin
    req_s = bus.for_request;
    cnt_s = bus.enc_count;
    if (bus.for_request > CW'(SYM_NUM)) begin
      req_s = CW'(SYM_NUM);
    end else begin
      req_s = bus.for_request;
    end
    if (bus.enc_count > CW'(SYM_NUM)) begin
      cnt_s = CW'(SYM_NUM);
    end else begin
      cnt_s = bus.enc_count;
    end
  end

  // Ready depends only on registered state: room for a whole beat and no
  // frame end still waiting to drain (one frame in the buffer at a time).
  assign ready_s = rst_n && !last_pend_r &&
                   ((LW'(BUF_SYM) - level_r) >= LW'(SYM_NUM));

  // Output selection: a full request if enough symbols are buffered,
  // otherwise flush what is left of a terminated frame.
  always_comb begin
    out_valid_s = 1'b0;
    out_count_s = '0;
    out_last_s  = 1'b0;
    if ((req_s != '0) && (level_r >= LW'(req_s))) begin
      out_valid_s = 1'b1;
      out_count_s = req_s;
      out_last_s  = last_pend_r && (last_pos_r == LW'(req_s));
    end else if (last_pend_r && (level_r < LW'(req_s))) begin
      // level_r < req_s <= SYM_NUM, so the narrowing is lossless; an empty
      // terminator yields a zero-count beat carrying only for_last.
      out_valid_s = 1'b1;
      out_count_s = CW'(level_r);
      out_last_s  = 1'b1;
    end else begin
      out_valid_s = 1'b0;
      out_count_s = '0;
      out_last_s  = 1'b0;
    end
  end

  // Present the oldest symbols, zeroing lanes beyond the delivered count.
  always_comb begin
    out_data_s = '0;
    for (int i = 0; i < SYM_NUM; i++) begin
      if (CW'(i) < out_count_s) begin
        out_data_s[i*SYM_WIDTH +: SYM_WIDTH] = buf_r[i*SYM_WIDTH +: SYM_WIDTH];
      end else begin
        out_data_s[i*SYM_WIDTH +: SYM_WIDTH] = {SYM_WIDTH{1'b0}};
      end
    end
  end

  assign push_s   = bus.enc_valid && ready_s;
  assign push_n_s = push_s ? cnt_s : '0;
  assign pop_n_s  = out_valid_s ? out_count_s : '0;
  assign keep_s   = level_r - LW'(pop_n_s);

  // Mask incoming lanes past the push count and build the keep window.
  always_comb begin
    push_data_s = '0;
    keep_mask_s = '0;
    for (int i = 0; i < SYM_NUM; i++) begin
      if (CW'(i) < push_n_s) begin
        push_data_s[i*SYM_WIDTH +: SYM_WIDTH] = bus.enc_data[i*SYM_WIDTH +: SYM_WIDTH];
      end else begin
        push_data_s[i*SYM_WIDTH +: SYM_WIDTH] = {SYM_WIDTH{1'b0}};
      end
    end
    for (int j = 0; j < BUF_SYM; j++) begin
      if (LW'(j) < keep_s) begin
        keep_mask_s[j*SYM_WIDTH +: SYM_WIDTH] = {SYM_WIDTH{1'b1}};
      end else begin
        keep_mask_s[j*SYM_WIDTH +: SYM_WIDTH] = {SYM_WIDTH{1'b0}};
      end
    end
  end

  // Shift out popped symbols and append the new beat right behind the
  // survivors, so simultaneous push/pop keeps symbol order.
  assign buf_next_s = ((buf_r >> (int'(pop_n_s) * SYM_WIDTH)) & keep_mask_s) |
                      (BW'(push_data_s) << (int'(keep_s) * SYM_WIDTH));
  assign level_next_s = keep_s + LW'(push_n_s);

  // Frame-end tracking: last_pos follows the final symbol as the head moves.
  always_comb begin
    last_pend_next_s = last_pend_r;
    last_pos_next_s  = last_pos_r;
    if (push_s && bus.enc_last) begin
      last_pend_next_s = 1'b1;
      last_pos_next_s  = level_next_s;
    end else if (last_pend_r) begin
      last_pos_next_s = last_pos_r - LW'(pop_n_s);
      if (out_last_s) begin
        last_pend_next_s = 1'b0;
      end else begin
        last_pend_next_s = 1'b1;
      end
    end else begin
      last_pend_next_s = last_pend_r;
      last_pos_next_s  = last_pos_r;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r       <= '0;
      level_r     <= '0;
      last_pend_r <= 1'b0;
      last_pos_r  <= '0;
    end else begin
      buf_r       <= buf_next_s;
      level_r     <= level_next_s;
      last_pend_r <= last_pend_next_s;
      last_pos_r  <= last_pos_next_s;
    end
  end

  assign bus.enc_ready = ready_s;
  assign bus.for_valid = out_valid_s;
  assign bus.for_count = out_count_s;
  assign bus.for_last  = out_last_s;
  assign bus.for_data  = out_data_s;
  assign bus.buf_level = level_r;

endmodule
